// File: rtl/trivium_pkg.sv
// Shared Trivium constants: state geometry, tap positions (1-based s(i)) and the
// keystream FSM encoding used by the round logic and the keystream stage.
package trivium_pkg;

    localparam int STATE_W = 288;
    localparam int KEY_W   = 80;
    localparam int IV_W    = 80;

    // Register boundaries: A = s1..s93, B = s94..s177, C = s178..s288
    localparam int REG_A_END = 93;
    localparam int REG_B_END = 177;
    localparam int REG_C_END = 288;

    localparam int TAP_T1_A     = 66;
    localparam int TAP_T1_B     = 93;
    localparam int TAP_T1_AND_A = 91;
    localparam int TAP_T1_AND_B = 92;
    localparam int TAP_T1_FB    = 171;
    localparam int TAP_T2_A     = 162;
    localparam int TAP_T2_B     = 177;
    localparam int TAP_T2_AND_A = 175;
    localparam int TAP_T2_AND_B = 176;
    localparam int TAP_T2_FB    = 264;
    localparam int TAP_T3_A     = 243;
    localparam int TAP_T3_B     = 288;
    localparam int TAP_T3_AND_A = 286;
    localparam int TAP_T3_AND_B = 287;
    localparam int TAP_T3_FB    = 69;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_HOLD = 2'd2
    } ks_state_e;

    // Reads s(idx) from a state vector stored as vec[idx-1]
    function automatic logic tap(input logic [STATE_W-1:0] vec, input int idx);
        return vec[idx-1];
    endfunction

endpackage

// File: rtl/trivium_keystream_if.sv
// Load + keystream handshake bundle between the init stage, the keystream
// stage (master) and the keystream consumer (slave).
interface trivium_keystream_if #(
    parameter int W     = 8,
    parameter int LEN_W = 16
);
    import trivium_pkg::*;

    logic                load;
    logic [STATE_W-1:0]  state_in;
    logic [LEN_W-1:0]    len;
    logic [W-1:0]        ks_data;
    logic                ks_valid;
    logic                ks_ready;
    logic                busy;
    logic                done;

    modport master (
        input  load, state_in, len, ks_ready,
        output ks_data, ks_valid, busy, done
    );

    modport slave (
        output load, state_in, len, ks_ready,
        input  ks_data, ks_valid, busy, done
    );

endinterface

// File: rtl/trivium_round.sv
// One combinational Trivium update step; shared by the init engine and the
// keystream stage so both use the same round definition.
module trivium_round
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    output logic [STATE_W-1:0] state_out,
    output logic               z
);

    logic t1_s;
    logic t2_s;
    logic t3_s;
    logic t1_fb_s;
    logic t2_fb_s;
    logic t3_fb_s;

    assign t1_s = tap(state_in, TAP_T1_A) ^ tap(state_in, TAP_T1_B);
    assign t2_s = tap(state_in, TAP_T2_A) ^ tap(state_in, TAP_T2_B);
    assign t3_s = tap(state_in, TAP_T3_A) ^ tap(state_in, TAP_T3_B);

    assign z = t1_s ^ t2_s ^ t3_s;

    assign t1_fb_s = t1_s ^ (tap(state_in, TAP_T1_AND_A) & tap(state_in, TAP_T1_AND_B))
                          ^ tap(state_in, TAP_T1_FB);
    assign t2_fb_s = t2_s ^ (tap(state_in, TAP_T2_AND_A) & tap(state_in, TAP_T2_AND_B))
                          ^ tap(state_in, TAP_T2_FB);
    assign t3_fb_s = t3_s ^ (tap(state_in, TAP_T3_AND_A) & tap(state_in, TAP_T3_AND_B))
                          ^ tap(state_in, TAP_T3_FB);

    // Each register shifts toward higher s(i); feedback enters at its first cell
    assign state_out = {state_in[REG_C_END-2:REG_B_END], t2_fb_s,
                        state_in[REG_B_END-2:REG_A_END], t1_fb_s,
                        state_in[REG_A_END-2:0],         t3_fb_s};

endmodule

// File: rtl/trivium_keystream.sv
// Trivium keystream stage: runs the round once per cycle from a loaded state,
// packs bits LSB-first into W-bit words and delivers len words over valid/ready.
module trivium_keystream
    import trivium_pkg::*;
#(
    parameter int W     = 8,
    parameter int LEN_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    trivium_keystream_if.master bus
);

    localparam int BITCNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(W - 1);

    ks_state_e              state_r;
    ks_state_e              state_nxt_s;
    logic [STATE_W-1:0]     cipher_r;
    logic [STATE_W-1:0]     cipher_nxt_s;
    logic [W-1:0]           word_r;
    logic [W-1:0]           word_nxt_s;
    logic [BITCNT_W-1:0]    bitcnt_r;
    logic [BITCNT_W-1:0]    bitcnt_nxt_s;
    logic [LEN_W-1:0]       remaining_r;
    logic [LEN_W-1:0]       remaining_nxt_s;
    logic [W-1:0]           ks_data_r;
    logic [W-1:0]           ks_data_nxt_s;
    logic                   ks_valid_r;
    logic                   ks_valid_nxt_s;
    logic                   busy_r;
    logic                   busy_nxt_s;
    logic                   done_r;
    logic                   done_nxt_s;
    logic [STATE_W-1:0]     round_state_s;
    logic                   round_z_s;

    trivium_round u_round (
        .state_in  (cipher_r),
        .state_out (round_state_s),
        .z         (round_z_s)
    );

    // Next-state and datapath decode; load overrides whatever the FSM is doing
    always_comb begin
        state_nxt_s     = state_r;
        cipher_nxt_s    = cipher_r;
        word_nxt_s      = word_r;
        bitcnt_nxt_s    = bitcnt_r;
        remaining_nxt_s = remaining_r;
        ks_data_nxt_s   = ks_data_r;
        ks_valid_nxt_s  = ks_valid_r;
        done_nxt_s      = 1'b0;

        if (bus.load) begin
            cipher_nxt_s    = bus.state_in;
            remaining_nxt_s = bus.len;
            bitcnt_nxt_s    = {BITCNT_W{1'b0}};
            word_nxt_s      = {W{1'b0}};
            ks_valid_nxt_s  = 1'b0;
            if (bus.len != {LEN_W{1'b0}}) begin
                state_nxt_s = ST_GEN;
            end else begin
                state_nxt_s = ST_IDLE;
                done_nxt_s  = 1'b1;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_GEN: begin
                    cipher_nxt_s           = round_state_s;
                    word_nxt_s[bitcnt_r]   = round_z_s;
                    if (bitcnt_r == LAST_BIT) begin
                        ks_data_nxt_s   = word_nxt_s;
                        ks_valid_nxt_s  = 1'b1;
                        remaining_nxt_s = remaining_r - LEN_W'(1);
                        bitcnt_nxt_s    = {BITCNT_W{1'b0}};
                        state_nxt_s     = ST_HOLD;
                    end else begin
                        bitcnt_nxt_s    = bitcnt_r + BITCNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // Cipher state stays frozen here; only the handshake advances
                    if (bus.ks_ready) begin
                        ks_valid_nxt_s = 1'b0;
                        if (remaining_r != {LEN_W{1'b0}}) begin
                            state_nxt_s = ST_GEN;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            done_nxt_s  = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s    = ST_IDLE;
                    ks_valid_nxt_s = 1'b0;
                end
            endcase
        end
    end

    assign busy_nxt_s = (state_nxt_s != ST_IDLE);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Cipher state, word assembly, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cipher_r    <= {STATE_W{1'b0}};
            word_r      <= {W{1'b0}};
            bitcnt_r    <= {BITCNT_W{1'b0}};
            remaining_r <= {LEN_W{1'b0}};
            ks_data_r   <= {W{1'b0}};
            ks_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cipher_r    <= cipher_nxt_s;
            word_r      <= word_nxt_s;
            bitcnt_r    <= bitcnt_nxt_s;
            remaining_r <= remaining_nxt_s;
            ks_data_r   <= ks_data_nxt_s;
            ks_valid_r  <= ks_valid_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign bus.ks_data  = ks_data_r;
    assign bus.ks_valid = ks_valid_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_trivium_keystream.sv
// Randomized self-checking bench for trivium_keystream against a bit-level
// Trivium reference model (1-indexed state array, plain shifting).
module tb_trivium_keystream;

    localparam int W     = 8;
    localparam int LEN_W = 16;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [288:1]  ms;
    logic [W-1:0]  exp_q[$];

    trivium_keystream_if #(.W(W), .LEN_W(LEN_W)) bus ();

    trivium_keystream #(.W(W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    task automatic model_load(input logic [287:0] st);
        for (int i = 1; i <= 288; i++) ms[i] = st[i-1];
    endtask

    task automatic model_step(output logic z);
        logic t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93; i > 1; i--)    ms[i] = ms[i-1];
        for (int i = 177; i > 94; i--)  ms[i] = ms[i-1];
        for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
        ms[1]   = t3;
        ms[94]  = t1;
        ms[178] = t2;
    endtask

    task automatic model_words(input logic [287:0] st, input int n);
        logic z;
        logic [W-1:0] w;
        model_load(st);
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < W; b++) begin
                model_step(z);
                w[b] = z;
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic model_init(input logic [79:0] key, input logic [79:0] iv,
                              output logic [287:0] st);
        logic z;
        ms = '0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = key[i-1];
            ms[93 + i] = iv[i-1];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
        for (int r = 0; r < 1152; r++) model_step(z);
        for (int i = 1; i <= 288; i++) st[i-1] = ms[i];
    endtask

    function automatic logic [287:0] rand_state();
        logic [287:0] st;
        for (int i = 0; i < 9; i++) st[i*32 +: 32] = $urandom;
        return st;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_load(input logic [287:0] st, input int n);
        bus.state_in = st;
        bus.len      = LEN_W'(n);
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    // Consumes a run already loaded; exp_q must hold the expected words
    task automatic collect(input int n, input int stall_pct, input int hold_first,
                           input string tag, output logic [W-1:0] first_word);
        int           got;
        int           held;
        int           budget;
        bit           seen_done;
        bit           prev_hold;
        logic [W-1:0] prev_d;
        got = 0; held = 0; seen_done = 0; prev_hold = 0; prev_d = '0;
        first_word = '0;
        budget = 100 + n * (W + 1) * 4 + hold_first;
        for (int c = 0; c < budget && !seen_done; c++) begin
            if (bus.ks_valid === 1'b1 && got == 0 && held < hold_first) begin
                bus.ks_ready = 1'b0;
                held++;
            end else begin
                bus.ks_ready = ($urandom_range(99) >= stall_pct);
            end
            total++;
            if (bus.ks_valid === 1'b1 && bus.done === 1'b1) begin
                bad++;
                $display("FAIL %s valid_done_overlap: got both high want exclusive", tag);
            end
            if (bus.done === 1'b1) seen_done = 1;
            total++;
            if (bus.busy !== !seen_done) begin
                bad++;
                $display("FAIL %s busy: got %b want %b", tag, bus.busy, !seen_done);
            end
            if (bus.ks_valid === 1'b1) begin
                if (prev_hold) begin
                    total++;
                    if (bus.ks_data !== prev_d) begin
                        bad++;
                        $display("FAIL %s data_stable: got %h want %h", tag, bus.ks_data, prev_d);
                    end
                end
                if (bus.ks_ready) begin
                    total++;
                    if (got >= n) begin
                        bad++;
                        $display("FAIL %s extra_word: got %h want none", tag, bus.ks_data);
                    end else if (bus.ks_data !== exp_q[got]) begin
                        bad++;
                        $display("FAIL %s word%0d: got %h want %h", tag, got, bus.ks_data, exp_q[got]);
                    end
                    if (got == 0) first_word = bus.ks_data;
                    got++;
                    prev_hold = 0;
                end else begin
                    prev_hold = 1;
                    prev_d    = bus.ks_data;
                end
            end else begin
                prev_hold = 0;
            end
            if (!seen_done) tick();
        end
        total++;
        if (!seen_done) begin
            bad++;
            $display("FAIL %s done_timeout: got no done want done within %0d cycles", tag, budget);
        end
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL %s word_count: got %0d want %0d", tag, got, n);
        end
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.ks_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done: got done=%b busy=%b valid=%b want 0 0 0",
                     tag, bus.done, bus.busy, bus.ks_valid);
        end
    endtask

    task automatic run_stream(input logic [287:0] st, input int n, input int stall_pct,
                              input int hold_first, input string tag,
                              output logic [W-1:0] first_word);
        model_words(st, n);
        do_load(st, n);
        collect(n, stall_pct, hold_first, tag, first_word);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if (bus.ks_data !== '0 || bus.ks_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got data=%h valid=%b busy=%b done=%b want 0",
                     bus.ks_data, bus.ks_valid, bus.busy, bus.done);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        logic exp_v;
        logic exp_d;
        logic exp_b;
        bus.ks_ready = 1'b1;
        do_load('0, 3);
        for (int c = 0; c <= 3 * W + 5; c++) begin
            exp_v = (c == W) || (c == 2 * W + 1) || (c == 3 * W + 2);
            exp_d = (c == 3 * W + 3);
            exp_b = (c <= 3 * W + 2);
            total++;
            if (bus.ks_valid !== exp_v) begin
                bad++;
                $display("FAIL latency_valid c=%0d: got %b want %b", c, bus.ks_valid, exp_v);
            end
            total++;
            if (bus.done !== exp_d) begin
                bad++;
                $display("FAIL latency_done c=%0d: got %b want %b", c, bus.done, exp_d);
            end
            total++;
            if (bus.busy !== exp_b) begin
                bad++;
                $display("FAIL latency_busy c=%0d: got %b want %b", c, bus.busy, exp_b);
            end
            if (exp_v) begin
                total++;
                if (bus.ks_data !== '0) begin
                    bad++;
                    $display("FAIL latency_data c=%0d: got %h want 00", c, bus.ks_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_single_tap();
        logic [287:0] st;
        logic [W-1:0] fw;
        st = '0;
        st[65] = 1'b1;
        run_stream(st, 1, 0, 0, "single_tap", fw);
        total++;
        if (fw !== 8'h01) begin
            bad++;
            $display("FAIL single_tap_word: got %h want 01", fw);
        end
    endtask

    task automatic test_len_zero();
        bus.ks_ready = 1'b1;
        do_load(rand_state(), 0);
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.ks_valid !== 1'b0) begin
            bad++;
            $display("FAIL len_zero_pulse: got done=%b busy=%b valid=%b want 1 0 0",
                     bus.done, bus.busy, bus.ks_valid);
        end
        for (int c = 0; c < W + 3; c++) begin
            tick();
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.ks_valid !== 1'b0) begin
                bad++;
                $display("FAIL len_zero_idle c=%0d: got done=%b busy=%b valid=%b want 0 0 0",
                         c, bus.done, bus.busy, bus.ks_valid);
            end
        end
    endtask

    task automatic test_streams();
        logic [W-1:0] fw;
        for (int r = 0; r < 3; r++) run_stream(rand_state(), $urandom_range(5, 1), 0, 0, "stream_fast", fw);
        for (int r = 0; r < 4; r++) run_stream(rand_state(), $urandom_range(6, 1), 40, 0, "stream_stall", fw);
    endtask

    task automatic test_stall();
        logic [W-1:0] fw;
        run_stream(rand_state(), 3, 0, 10, "hold10", fw);
    endtask

    task automatic test_chain();
        logic [287:0] st;
        logic [W-1:0] fw;
        model_init(80'h0, 80'h0000123456789abcdef, st);
        run_stream(st, 16, 25, 0, "chain", fw);
    endtask

    task automatic test_abort_hold();
        logic [287:0] st_b;
        logic [W-1:0] fw;
        int           c;
        bus.ks_ready = 1'b0;
        do_load(rand_state(), 1);
        c = 0;
        while (bus.ks_valid !== 1'b1 && c < W + 5) begin
            tick();
            c++;
        end
        total++;
        if (bus.ks_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort_reach_hold: got valid=%b want 1", bus.ks_valid);
        end
        st_b = rand_state();
        model_words(st_b, 2);
        bus.ks_ready = 1'b1;
        do_load(st_b, 2);
        total++;
        if (bus.ks_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_load: got valid=%b done=%b busy=%b want 0 0 1",
                     bus.ks_valid, bus.done, bus.busy);
        end
        collect(2, 30, 0, "abort_new", fw);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] fw;
        bus.ks_ready = 1'b1;
        do_load(rand_state(), 4);
        tick();
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus.ks_data !== '0 || bus.ks_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got data=%h valid=%b busy=%b done=%b want 0",
                     bus.ks_data, bus.ks_valid, bus.busy, bus.done);
        end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 4 * (W + 1); c++) begin
            tick();
            total++;
            if (bus.done !== 1'b0 || bus.ks_valid !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_quiet c=%0d: got done=%b valid=%b busy=%b want 0 0 0",
                         c, bus.done, bus.ks_valid, bus.busy);
            end
        end
        run_stream(rand_state(), 2, 20, 0, "after_reset", fw);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b0;
        bus.load     = 1'b0;
        bus.state_in = '0;
        bus.len      = '0;
        bus.ks_ready = 1'b0;
        test_reset();
        test_latency();
        test_single_tap();
        test_len_zero();
        test_streams();
        test_stall();
        test_chain();
        test_abort_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trivium_keystream.md
Name: trivium_keystream

Overview:
- Downstream stage of the Trivium init engine (ENCRIPT). Takes the 288-bit state after the 1152 init rounds and runs the Trivium update once per cycle.
- Packs the keystream bits into W-bit words and hands them to the consumer over a valid/ready interface.
- Produces exactly `len` words per load, then pulses `done`.

Parameters:
- W, 8, keystream word width in bits (legal 1..64).
- LEN_W, 16, width of the word-count input.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low: reset==0 resets immediately.
- load  in  1  one-cycle pulse; samples state_in and len.
- state_in  in  288  initialized Trivium state from the init stage; state_in[i-1] = s(i), i = 1..288.
- len  in  LEN_W  number of W-bit words to produce for this load.
- ks_data  out  W  keystream word; the first generated bit is in ks_data[0] (LSB first).
- ks_valid  out  1  ks_data holds a word.
- ks_ready  in  1  consumer accepts the word on a clock edge where ks_valid && ks_ready.
- busy  out  1  high in GEN or HOLD.
- done  out  1  one-cycle pulse after the last word is accepted, or after a load with len==0.

Behaviour:
- Reset (reset==0, asynchronous): state register=0, word shift register=0, bit counter=0, word counter=0, FSM=IDLE, ks_data=0, ks_valid=0, busy=0, done=0.
- Round function (s(i) 1-indexed):
  - t1=s66^s93, t2=s162^s177, t3=s243^s288; z=t1^t2^t3.
  - t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69.
  - Shift: (s1..s93)<=(t3,s1..s92); (s94..s177)<=(t1,s94..s176); (s178..s288)<=(t2,s178..s287).
- FSM states: IDLE, GEN, HOLD.
- IDLE: outputs quiescent. On load: state<=state_in, remaining<=len, bitcnt<=0.
  - len!=0 -> GEN.
  - len==0 -> done=1 on the next cycle, stay IDLE.
- GEN: each cycle compute z, shift z into word bit position bitcnt, update the state, bitcnt++.
  - At the edge where bitcnt==W-1: ks_data<=complete word, ks_valid<=1, remaining--, bitcnt<=0, -> HOLD.
- HOLD: cipher state frozen; ks_data stable while ks_valid && !ks_ready.
  - On the edge with ks_ready: ks_valid<=0.
    - remaining!=0 -> GEN.
    - remaining==0 -> IDLE, with done=1 for the following cycle.
- Latency: first ks_valid rises W edges after the load edge (first visible after edge W, counting the load edge as 0).
- Throughput: one word per W+1 cycles with ks_ready held high; the HOLD cycle is the bubble.
- Keystream continuity: consecutive words form a contiguous keystream; no bits are skipped or repeated across stalls.
- load in GEN or HOLD: aborts the current run with no done pulse for the aborted run. ks_valid<=0, the new state and len are loaded, and the FSM follows the IDLE load rules.
  - load has priority over a simultaneous ks_valid&&ks_ready; that word counts as dropped.
- ks_ready while ks_valid==0: ignored.
- Reset mid-run: immediate return to reset values; a pending word is lost.
- remaining is unsigned with no wrap: len=2^LEN_W-1 produces exactly that many words.
- done and ks_valid are never high in the same cycle.

Decomposition:
- Package trivium_pkg:
  - STATE_W=288, KEY_W=80, IV_W=80.
  - Tap-index constants (66,93,91,92,171,162,177,175,176,264,243,288,286,287,69).
  - Register-boundary constants 93/177/288.
  - FSM state enum.
- Sub-module trivium_round: purely combinational one-step update (state_in -> state_out, z). Shared with the init engine so both stages use one round definition.

Test Plan:
- state_in=0, len=3, ks_ready=1 -> three words of 0x00, ks_valid high on cycles W, 2W+1 and 3W+2 after the load edge, then one done pulse.
- state_in with only bit 65 (s66)=1, W=8, len=1 -> ks_data=0x01, then done.
- len=0 load -> no ks_valid, done high exactly one cycle after the load edge, busy stays 0.
- Hold ks_ready=0 for 10 cycles after the first word -> ks_data and state frozen. Release: the second word matches the C reference model. Run with both stalled and unstalled streams and compare against the model.
- Chain: init engine with KEY=80'h0, IV=80'h0000123456789abcdef, 1152 rounds -> feed STRM, len=16 -> 128 keystream bits match the C reference model.
- load asserted during HOLD, and reset driven low mid-GEN -> the aborted run produces no done pulse. After the re-load, the new stream starts from the new state; after reset, all outputs read 0 immediately.
